// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with two combinational read
// ports, one write port, a per-register busy (pending-result) scoreboard and
// a multi-cycle clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward write data to a read
// port addressing the register being written in the same cycle.
module regfile_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeEN,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddrA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] rdDataA,
  output logic [WIDTH-1:0] rdDataB,
  input  logic             rsvEN,
  input  logic [AW-1:0]    rsvAddr,
  output logic             busyA,
  output logic             busyB,
  input  logic             clrReq,
  output logic             clrBusy,
  output logic             clrDone
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             wr_ok, rsv_ok;

  assign clrBusy = (state_q == ST_SWEEP);
  assign clrDone = (state_q == ST_DONE);
  assign wr_ok   = writeEN && !clrBusy;
  assign rsv_ok  = rsvEN && !clrBusy;

  // Clear-sweep controller next-state and pointer logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clrReq) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Register array and busy bits: reset, sweep, write, then reserve (reserve
  // is assigned last so it wins over a same-address write's busy clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (clrBusy) begin
        regs_q[ptr_q] <= '0;
        busy_q[ptr_q] <= 1'b0;
      end
      if (wr_ok) begin
        regs_q[wrAddr] <= wrData;
        busy_q[wrAddr] <= 1'b0;
      end
      if (rsv_ok) busy_q[rsvAddr] <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b, rsv_same;

  assign fwd_a    = wr_ok && (wrAddr == rdAddrA);
  assign fwd_b    = wr_ok && (wrAddr == rdAddrB);
  assign rsv_same = rsvEN && (rsvAddr == wrAddr);

  // Combinational read ports with same-cycle write forwarding.
  always_comb begin
    rdDataA = fwd_a ? wrData : regs_q[rdAddrA];
    rdDataB = fwd_b ? wrData : regs_q[rdAddrB];
    busyA   = (fwd_a && !rsv_same) ? 1'b0 : busy_q[rdAddrA];
    busyB   = (fwd_b && !rsv_same) ? 1'b0 : busy_q[rdAddrB];
  end
`else
  // Combinational read ports returning stored contents.
  always_comb begin
    rdDataA = regs_q[rdAddrA];
    rdDataB = regs_q[rdAddrB];
    busyA   = busy_q[rdAddrA];
    busyB   = busy_q[rdAddrB];
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (WIDTH=16/DEPTH=8 and WIDTH=32/DEPTH=16).
module tb_regfile_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size DUT signals
  logic        rst, writeEN, rsvEN, clrReq;
  logic [2:0]  wrAddr, rdAddrA, rdAddrB, rsvAddr;
  logic [15:0] wrData, rdDataA, rdDataB;
  logic        busyA, busyB, clrBusy, clrDone;

  // Large DUT signals
  logic        b_rst, b_writeEN, b_rsvEN, b_clrReq;
  logic [3:0]  b_wrAddr, b_rdAddrA, b_rdAddrB, b_rsvAddr;
  logic [31:0] b_wrData, b_rdDataA, b_rdDataB;
  logic        b_busyA, b_busyB, b_clrBusy, b_clrDone;

  regfile_param #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .writeEN(writeEN), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
    .rsvEN(rsvEN), .rsvAddr(rsvAddr), .busyA(busyA), .busyB(busyB),
    .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone)
  );

  regfile_param #(.WIDTH(32), .DEPTH(16)) dut_big (
    .clk(clk), .rst(b_rst), .writeEN(b_writeEN), .wrAddr(b_wrAddr), .wrData(b_wrData),
    .rdAddrA(b_rdAddrA), .rdAddrB(b_rdAddrB), .rdDataA(b_rdDataA), .rdDataB(b_rdDataB),
    .rsvEN(b_rsvEN), .rsvAddr(b_rsvAddr), .busyA(b_busyA), .busyB(b_busyB),
    .clrReq(b_clrReq), .clrBusy(b_clrBusy), .clrDone(b_clrDone)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rsv;
    logic [2:0]  ra;
    logic [2:0]  rda;
    logic [2:0]  rdb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_ba;
    logic        exp_bb;
  } vec_t;

  typedef struct {
    logic [2:0]  rda;
    logic [2:0]  rdb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_ba;
    logic        exp_bb;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  initial begin
    exp_t e;
    int   cnt;
    int   budget;
    int   pulses;
    logic done_seen;

    //         we  wa   wd        rsv ra   rda  rdb  expA      expB      bA  bB
    vecs[0] = '{1, 3'd2, 16'd15,   0, 3'd0, 3'd2, 3'd0, 16'd15,   16'd0,    0, 0};
    vecs[1] = '{1, 3'd4, 16'd8,    0, 3'd0, 3'd4, 3'd2, 16'd8,    16'd15,   0, 0};
    vecs[2] = '{0, 3'd0, 16'd0,    1, 3'd5, 3'd5, 3'd4, 16'd0,    16'd8,    1, 0};
    vecs[3] = '{1, 3'd5, 16'h00AA, 0, 3'd0, 3'd5, 3'd5, 16'h00AA, 16'h00AA, 0, 0};
    vecs[4] = '{1, 3'd6, 16'h0055, 1, 3'd6, 3'd6, 3'd5, 16'h0055, 16'h00AA, 1, 0};
    vecs[5] = '{1, 3'd0, 16'hBEEF, 1, 3'd1, 3'd0, 3'd1, 16'hBEEF, 16'd0,    0, 1};
    vecs[6] = '{1, 3'd1, 16'h1111, 0, 3'd0, 3'd1, 3'd7, 16'h1111, 16'd0,    0, 0};
    vecs[7] = '{1, 3'd7, 16'hFFFF, 0, 3'd0, 3'd7, 3'd6, 16'hFFFF, 16'h0055, 0, 1};

    rst = 1; writeEN = 0; rsvEN = 0; clrReq = 0;
    wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0; rsvAddr = '0;
    b_rst = 1; b_writeEN = 0; b_rsvEN = 0; b_clrReq = 0;
    b_wrAddr = '0; b_wrData = '0; b_rdAddrA = '0; b_rdAddrB = '0; b_rsvAddr = '0;

    // Reset for two cycles, then every address must read zero / not busy
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; b_rst = 0;
    check("rst_clrBusy", {31'd0, clrBusy}, 32'd0);
    check("rst_clrDone", {31'd0, clrDone}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rdAddrA = 3'(i); rdAddrB = 3'(7 - i);
      #1;
      check("rst_dataA", {16'd0, rdDataA}, 32'd0);
      check("rst_dataB", {16'd0, rdDataB}, 32'd0);
      check("rst_busyAB", {30'd0, busyA, busyB}, 32'd0);
    end

    // Table-driven write/reserve vectors through the scoreboard
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      writeEN = vecs[i].we; wrAddr = vecs[i].wa; wrData = vecs[i].wd;
      rsvEN = vecs[i].rsv; rsvAddr = vecs[i].ra;
      sb.push_back('{vecs[i].rda, vecs[i].rdb, vecs[i].exp_a, vecs[i].exp_b,
                     vecs[i].exp_ba, vecs[i].exp_bb});
      @(posedge clk);
      #1;
      writeEN = 0; rsvEN = 0;
      e = sb.pop_front();
      rdAddrA = e.rda; rdAddrB = e.rdb;
      #1;
      check($sformatf("vec%0d_dataA", i), {16'd0, rdDataA}, {16'd0, e.exp_a});
      check($sformatf("vec%0d_dataB", i), {16'd0, rdDataB}, {16'd0, e.exp_b});
      check($sformatf("vec%0d_busyA", i), {31'd0, busyA}, {31'd0, e.exp_ba});
      check($sformatf("vec%0d_busyB", i), {31'd0, busyB}, {31'd0, e.exp_bb});
    end

    // Same-cycle write to R3 while reading it
    @(negedge clk);
    writeEN = 1; wrAddr = 3'd3; wrData = 16'h1234; rdAddrA = 3'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_before_edge", {16'd0, rdDataA}, 32'h1234);
`else
    check("bypass_before_edge", {16'd0, rdDataA}, 32'h0000);
`endif
    @(posedge clk);
    #1;
    writeEN = 0;
    #1;
    check("bypass_after_edge", {16'd0, rdDataA}, 32'h1234);

    // Clear sweep: fill all with 0xFFFF, reserve R1, then clear while
    // holding a write to R7 and a reserve of R0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      writeEN = 1; wrAddr = 3'(i); wrData = 16'hFFFF;
    end
    @(negedge clk);
    writeEN = 0; rsvEN = 1; rsvAddr = 3'd1;
    @(negedge clk);
    rsvEN = 0; rdAddrA = 3'd1;
    #1;
    check("pre_clear_busyR1", {31'd0, busyA}, 32'd1);
    clrReq = 1; writeEN = 1; wrAddr = 3'd7; wrData = 16'h1234;
    rsvEN = 1; rsvAddr = 3'd0;
    @(negedge clk);
    clrReq = 0;
    rdAddrA = 3'd1; rdAddrB = 3'd5;
    cnt = 0; budget = 40;
    while (clrBusy && budget > 0) begin
      if (cnt == 2) begin
        #1;
        check("sweep_swept_R1", {16'd0, rdDataA}, 32'd0);
        check("sweep_unswept_R5", {16'd0, rdDataB}, 32'hFFFF);
      end
      cnt++; budget--;
      @(negedge clk);
    end
    done_seen = clrDone;
    writeEN = 0; rsvEN = 0;
    check("sweep_cycles", cnt, 32'd8);
    check("sweep_clrDone", {31'd0, done_seen}, 32'd1);
    @(negedge clk);
    check("sweep_clrDone_one_cycle", {31'd0, clrDone}, 32'd0);
    check("sweep_idle_clrBusy", {31'd0, clrBusy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rdAddrA = 3'(i);
      #1;
      check($sformatf("clr_data_R%0d", i), {16'd0, rdDataA}, 32'd0);
      check($sformatf("clr_busy_R%0d", i), {31'd0, busyA}, 32'd0);
    end

    // Reset on the third sweep cycle aborts the sweep
    @(negedge clk);
    writeEN = 1; wrAddr = 3'd4; wrData = 16'h4444;
    @(negedge clk);
    writeEN = 0; clrReq = 1;
    @(negedge clk);
    clrReq = 0;
    cnt = 0; budget = 20;
    while (cnt < 2 && clrBusy && budget > 0) begin
      cnt++; budget--;
      @(negedge clk);
    end
    check("abort_in_sweep", {31'd0, clrBusy}, 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_clrBusy", {31'd0, clrBusy}, 32'd0);
    check("abort_clrDone", {31'd0, clrDone}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (clrDone || clrBusy) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rdAddrA = 3'(i);
      #1;
      check($sformatf("abort_data_R%0d", i), {16'd0, rdDataA}, 32'd0);
    end

    // Large configuration: 16-cycle sweep
    @(negedge clk);
    b_writeEN = 1; b_wrAddr = 4'd15; b_wrData = 32'hDEADBEEF;
    @(negedge clk);
    b_writeEN = 0; b_rsvEN = 1; b_rsvAddr = 4'd9;
    @(negedge clk);
    b_rsvEN = 0; b_rdAddrA = 4'd15; b_rdAddrB = 4'd9;
    #1;
    check("big_write", b_rdDataA, 32'hDEADBEEF);
    check("big_busy", {31'd0, b_busyB}, 32'd1);
    b_clrReq = 1;
    @(negedge clk);
    b_clrReq = 0;
    cnt = 0; budget = 60;
    while (b_clrBusy && budget > 0) begin
      cnt++; budget--;
      @(negedge clk);
    end
    check("big_sweep_cycles", cnt, 32'd16);
    check("big_clrDone", {31'd0, b_clrDone}, 32'd1);
    @(negedge clk);
    check("big_clear_data", b_rdDataA, 32'd0);
    check("big_clear_busy", {31'd0, b_busyB}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter: WIDTH, default 16, data width of each register in bits, at least 1.
REQ-002 Parameter: DEPTH, default 8, register count, a power of 2, at least 2.
REQ-003 Derived: AW = clog2(DEPTH), width of the address ports.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 writeEN  input  1  write enable.
REQ-007 wrAddr  input  AW  write address.
REQ-008 wrData  input  WIDTH  write data.
REQ-009 rdAddrA, rdAddrB  input  AW  read addresses for ports A and B.
REQ-010 rdDataA, rdDataB  output  WIDTH  read data for ports A and B.
REQ-011 rsvEN  input  1  reserve request: marks a register busy (pending result).
REQ-012 rsvAddr  input  AW  address to reserve.
REQ-013 busyA, busyB  output  1  busy bit of the register at rdAddrA / rdAddrB.
REQ-014 clrReq  input  1  request to clear the whole register file.
REQ-015 clrBusy  output  1  high while a clear sweep is in progress.
REQ-016 clrDone  output  1  one-cycle pulse when a clear sweep completes.

Function
REQ-017 Reads are combinational: rdDataX = reg[rdAddrX] and busyX = busy[rdAddrX].
REQ-018 When writeEN=1 and clrBusy=0, the block writes reg[wrAddr] <= wrData and clears busy[wrAddr] at the next edge.
REQ-019 When rsvEN=1 and clrBusy=0, the block sets busy[rsvAddr] at the next edge.
REQ-020 When writeEN and rsvEN target the same address in one cycle, the data is written and the busy bit ends at 1 (reserve wins).
REQ-021 Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on clrReq=1, with ptr <= 0.
  - clrReq is ignored outside IDLE.
REQ-022 In SWEEP, each cycle the block writes reg[ptr] <= 0, clears busy[ptr], and increments ptr.
  - When ptr = DEPTH-1, the next state is DONE.
  - The sweep lasts exactly DEPTH cycles.
REQ-023 DONE lasts one cycle, drives clrDone=1, then returns to IDLE.
REQ-024 clrBusy=1 exactly when the state is SWEEP.
REQ-025 During SWEEP, writeEN and rsvEN are ignored (no write, no busy change).
  - Reads stay live: registers not yet swept return their old contents; swept registers return 0.
REQ-026 ptr wraps naturally at AW bits; no out-of-range address is ever generated.

Reset
REQ-027 On rst=1 at an edge, the block sets:
  - all registers = 0 and all busy bits = 0;
  - state = IDLE, ptr = 0;
  - clrBusy = 0, clrDone = 0.
REQ-028 rst overrides every other input in the same cycle, including a sweep in progress, which is aborted.
REQ-029 After rst, rdDataA = rdDataB = 0 and busyA = busyB = 0 for every address.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
REQ-031 With REGFILE_BYPASS_EN defined, when writeEN=1, clrBusy=0 and wrAddr = rdAddrX:
  - rdDataX = wrData combinationally in the same cycle;
  - busyX = 0, unless rsvEN=1 with rsvAddr = wrAddr, in which case busyX = reg busy bit.
REQ-032 Without REGFILE_BYPASS_EN, reads return the stored value; new data is visible only after the write edge.

Verification
REQ-033 (WIDTH=16, DEPTH=8 unless noted) Reset: rst high for 2 cycles -> every address reads 0, busyA=busyB=0, clrBusy=0, clrDone=0.
REQ-034 Basic write/read:
  - Write 15 to R2; then rdAddrA=2, rdAddrB=0 -> A=15, B=0.
  - Write 8 to R4; then rdAddrA=4, rdAddrB=2 -> A=8, B=15.
REQ-035 Bypass: writeEN=1, wrAddr=3, wrData=0x1234, rdAddrA=3 in the same cycle.
  - With macro: rdDataA=0x1234 before the edge.
  - Without macro: 0 before the edge, 0x1234 after.
REQ-036 Scoreboard:
  - rsvEN to R5 -> busy=1 next cycle.
  - Write 0x00AA to R5 -> busy=0 and data=0x00AA.
  - Simultaneous rsv + write of 0x0055 to R6 -> busy=1 and data=0x0055.
REQ-037 Clear sweep: fill R0..R7 with 0xFFFF, reserve R1, pulse clrReq, and hold writeEN=1 to R7 during the sweep.
  - clrBusy is high for exactly 8 cycles, then clrDone is high for 1 cycle.
  - All registers read 0, all busy bits = 0, and the R7 write is ignored.
REQ-038 Reset mid-sweep: assert rst on the 3rd SWEEP cycle -> the next cycle shows state IDLE, clrBusy=0, clrDone never pulses, all registers 0.
  - Repeat the bench with WIDTH=32, DEPTH=16: the sweep lasts 16 cycles.
